// File: rtl/dlatch_bank_arbiter.sv
// dlatch_bank_arbiter: round-robin write controller for a bank of D-latch words.
// One write at a time runs a fixed SETUP -> GATE -> HOLD sequence. The shared
// data bus is therefore stable for a full cycle on each side of the gate pulse.
module dlatch_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      latch_d,
  output logic [(2**AW)-1:0]    latch_en,
  output logic                  busy
);

  localparam int NW = 2 ** AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, GATE, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;       // first requester examined in the next IDLE search
  logic [PW-1:0]   win_idx;   // requester currently being served
  logic [AW-1:0]   cap_addr;  // word address frozen at capture

  // Round-robin search result, used only in IDLE.
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [AW-1:0]   pick_addr;
  logic [WIDTH-1:0] pick_data;

  // Pick the first active requester starting at ptr and wrapping modulo NREQ.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold its old value.
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_addr  = '0;
    pick_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(idx);
        pick_addr  = addr[idx*AW +: AW];
        pick_data  = wdata[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Write sequencer: captures one request in IDLE, then steps through the gate
  // sequence with all outputs registered. latch_d doubles as the data capture
  // register; it only changes on the IDLE -> SETUP edge.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples pre-edge values, independent of statement order in this block.
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      win_idx  <= '0;
      cap_addr <= '0;
      latch_d  <= '0;
      latch_en <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= SETUP;
            win_idx  <= pick_idx;
            cap_addr <= pick_addr;
            latch_d  <= pick_data;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          state    <= GATE;
          latch_en <= NW'(1) << cap_addr;
        end
        GATE: begin
          state    <= HOLD;
          latch_en <= '0;
          gnt      <= NREQ'(1) << win_idx;
        end
        HOLD: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
        default: begin
          state    <= IDLE;
          latch_en <= '0;
          gnt      <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlatch_bank_arbiter.sv
// Self-checking bench for dlatch_bank_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level round-robin model.
module tb_dlatch_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int AW    = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      latch_d;
  logic [(2**AW)-1:0]    latch_en;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  // Outputs seen in the four cycles that follow a capture edge.
  typedef struct {
    logic [3:0][7:0] d;
    logic [3:0][3:0] en;
    logic [3:0][3:0] g;
    logic [3:0]      b;
  } obs_t;

  dlatch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .latch_d  (latch_d),
    .latch_en (latch_en),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One rising edge, then settle; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record outputs for the four cycles of one write, optionally scrambling
  // addr/wdata after the capture to prove they are ignored.
  task automatic observe(input bit scramble, output obs_t o);
    for (int c = 0; c < 4; c++) begin
      step();
      o.d[c]  = latch_d;
      o.en[c] = latch_en;
      o.g[c]  = gnt;
      o.b[c]  = busy;
      if (scramble) begin
        addr  = 8'($urandom);
        wdata = $urandom;
      end
    end
  endtask

  // Reference arbitration: scan ptr, ptr+1, ... modulo NREQ.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    wdata = '0;
    step();
    step();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (latch_d !== 8'h00) begin failures++; $display("FAIL reset_latch_d got=%h exp=00", latch_d); end
    checks++; if (latch_en !== 4'b0000) begin failures++; $display("FAIL reset_latch_en got=%b exp=0000", latch_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    obs_t o;
    apply_reset();
    addr  = 8'h02;
    wdata = 32'h0000_00A5;
    req   = 4'b0001;
    observe(1'b0, o);
    req = '0;
    checks++; if (o.d[0] !== 8'hA5 || o.en[0] !== 4'b0000) begin failures++; $display("FAIL single_setup got d=%h en=%b exp d=a5 en=0000", o.d[0], o.en[0]); end
    checks++; if (o.en[1] !== 4'b0100 || o.d[1] !== 8'hA5) begin failures++; $display("FAIL single_gate got en=%b d=%h exp en=0100 d=a5", o.en[1], o.d[1]); end
    checks++; if (o.g[2] !== 4'b0001 || o.en[2] !== 4'b0000) begin failures++; $display("FAIL single_hold got gnt=%b en=%b exp gnt=0001 en=0000", o.g[2], o.en[2]); end
    checks++; if (o.b !== 4'b0111) begin failures++; $display("FAIL single_busy got=%b exp=0111", o.b); end
  endtask

  task automatic test_contention();
    obs_t o;
    int exp_w[4] = '{1, 3, 1, 3};
    apply_reset();
    addr  = '0;
    wdata = 32'h4433_2211;
    req   = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      logic [3:0] eg;
      eg = 4'b0001 << exp_w[t];
      observe(1'b0, o);
      // Exactly one gnt in the four-cycle window, in the HOLD slot.
      checks++; if (o.g !== {4'b0000, eg, 4'b0000, 4'b0000}) begin failures++; $display("FAIL contention_gnt%0d got=%h exp=%h", t, o.g, {4'b0000, eg, 8'h00}); end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    obs_t o;
    apply_reset();
    addr  = {2'd3, 2'd2, 2'd1, 2'd0};
    wdata = 32'h1312_1110;
    req   = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [3:0] eg;
      logic [3:0] ee;
      logic [7:0] ed;
      int w;
      w  = t % NREQ;
      eg = 4'b0001 << w;
      ee = 4'b0001 << w;
      ed = 8'h10 + 8'(w);
      observe(1'b0, o);
      checks++; if (o.g[2] !== eg) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", t, o.g[2], eg); end
      checks++; if (o.en[1] !== ee) begin failures++; $display("FAIL rr_en%0d got=%b exp=%b", t, o.en[1], ee); end
      checks++; if (o.d[1] !== ed) begin failures++; $display("FAIL rr_d%0d got=%h exp=%h", t, o.d[1], ed); end
    end
    req = '0;
  endtask

  task automatic test_late_change();
    apply_reset();
    addr  = 8'h03;
    wdata = 32'h0000_003C;
    req   = 4'b0001;
    step();
    checks++; if (latch_d !== 8'h3C || latch_en !== 4'b0000) begin failures++; $display("FAIL late_setup got d=%h en=%b exp d=3c en=0000", latch_d, latch_en); end
    wdata = 32'h0000_00FF;
    addr  = 8'h00;
    req   = 4'b0000;
    step();
    checks++; if (latch_d !== 8'h3C || latch_en !== 4'b1000) begin failures++; $display("FAIL late_gate got d=%h en=%b exp d=3c en=1000", latch_d, latch_en); end
    step();
    checks++; if (latch_d !== 8'h3C || gnt !== 4'b0001) begin failures++; $display("FAIL late_hold got d=%h gnt=%b exp d=3c gnt=0001", latch_d, gnt); end
    step();
    step();
    checks++; if (busy !== 1'b0 || latch_d !== 8'h3C) begin failures++; $display("FAIL late_idle got busy=%b d=%h exp busy=0 d=3c", busy, latch_d); end
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    apply_reset();
    addr  = {2'd0, 2'd2, 2'd2, 2'd1};
    wdata = 32'h0000_5A77;
    req   = 4'b0001;
    step();
    step();
    checks++; if (latch_en !== 4'b0010) begin failures++; $display("FAIL midrst_gate got=%b exp=0010", latch_en); end
    rst_n = 1'b0;
    req   = 4'b0110;
    step();
    checks++; if (latch_en !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0 || latch_d !== 8'h00) begin failures++; $display("FAIL midrst_outputs got en=%b gnt=%b busy=%b d=%h exp all zero", latch_en, gnt, busy, latch_d); end
    rst_n = 1'b1;
    observe(1'b0, o);
    req = '0;
    checks++; if (o.g[2] !== 4'b0010 || o.en[1] !== 4'b0100 || o.d[1] !== 8'h5A) begin failures++; $display("FAIL midrst_winner got gnt=%b en=%b d=%h exp gnt=0010 en=0100 d=5a", o.g[2], o.en[1], o.d[1]); end
  endtask

  task automatic test_idle_stability();
    int bad;
    bad = 0;
    req = '0;
    for (int c = 0; c < 20; c++) begin
      addr  = 8'($urandom);
      wdata = $urandom;
      step();
      checks++;
      if (latch_d !== 8'h5A || latch_en !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        if (bad < 3) $display("FAIL idle_cycle%0d got d=%h en=%b gnt=%b busy=%b exp d=5a en=0000 gnt=0000 busy=0", c, latch_d, latch_en, gnt, busy);
        bad++;
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    int model_ptr;
    logic [7:0] last_d;
    apply_reset();
    model_ptr = 0;
    last_d    = 8'h00;
    for (int t = 0; t < 60; t++) begin
      logic [3:0] r;
      r     = 4'($urandom);
      addr  = 8'($urandom);
      wdata = $urandom;
      req   = r;
      if (r == 4'b0000) begin
        step();
        checks++; if (busy !== 1'b0 || latch_d !== last_d || latch_en !== 4'b0000 || gnt !== 4'b0000) begin failures++; $display("FAIL rand_idle%0d got busy=%b d=%h exp busy=0 d=%h", t, busy, latch_d, last_d); end
      end else begin
        int w;
        logic [1:0] ea;
        logic [7:0] ed;
        logic [3:0] ee;
        logic [3:0] eg;
        w  = rr_pick(r, model_ptr);
        ea = addr[w*AW +: AW];
        ed = wdata[w*WIDTH +: WIDTH];
        ee = 4'b0001 << ea;
        eg = 4'b0001 << w;
        observe(1'b1, o);
        checks++; if (o.d !== {ed, ed, ed, ed}) begin failures++; $display("FAIL rand_d%0d got=%h exp=%h", t, o.d, {ed, ed, ed, ed}); end
        checks++; if (o.en !== {4'b0000, 4'b0000, ee, 4'b0000}) begin failures++; $display("FAIL rand_en%0d got=%h exp=%h", t, o.en, {8'h00, ee, 4'b0000}); end
        checks++; if (o.g !== {4'b0000, eg, 4'b0000, 4'b0000}) begin failures++; $display("FAIL rand_gnt%0d got=%h exp=%h", t, o.g, {4'b0000, eg, 8'h00}); end
        checks++; if (o.b !== 4'b0111) begin failures++; $display("FAIL rand_busy%0d got=%b exp=0111", t, o.b); end
        model_ptr = (w + 1) % NREQ;
        last_d    = ed;
      end
    end
    req = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    wdata = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_round_robin();
    test_late_change();
    test_reset_mid_write();
    test_idle_stability();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlatch_bank_arbiter.md
# dlatch_bank_arbiter

Round-robin write controller for a bank of `Dlatch` storage words shared by several requesters. It picks one write at a time and drives the shared data bus and the per-word latch gate lines. Each write follows a fixed setup → gate → hold sequence, so a latch never goes transparent while its data is changing. It sits between requester logic and a register bank built from `Dlatch` cells; the bank itself is outside this block.

## Interface
- `NREQ`, default 4: number of requesters, at least 2.
- `WIDTH`, default 8: data width of one latch word.
- `AW`, default 2: address width. The bank has 2**AW words.

- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `req`, in, NREQ: per-requester write request, level.
- `addr`, in, NREQ*AW: packed addresses. Requester i uses bits [i*AW +: AW].
- `wdata`, in, NREQ*WIDTH: packed write data. Requester i uses bits [i*WIDTH +: WIDTH].
- `gnt`, out, NREQ: one-hot, one-cycle completion pulse to the winning requester.
- `latch_d`, out, WIDTH: shared data bus to all latch words.
- `latch_en`, out, 2**AW: one-hot gate, one line per latch word.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Every output is registered. No input-to-output combinational path.
- States: IDLE → SETUP → GATE → HOLD → IDLE.
- IDLE:
  - If any `req` bit is high, choose a winner by round-robin starting at pointer `ptr`.
  - Capture the winner's index, `addr` and `wdata` into internal registers, then go to SETUP.
  - If no `req` bit is high, stay in IDLE.
- SETUP: `latch_d` = captured data; `latch_en` all zero.
- GATE: `latch_en[captured addr]` = 1 and all other bits 0; `latch_d` unchanged.
- HOLD: `latch_en` all zero; `latch_d` unchanged; `gnt[winner]` = 1. Update `ptr` = (winner+1) mod NREQ. Next state is IDLE.
- Round-robin: search order is ptr, ptr+1, … wrapping modulo NREQ; the first high `req` wins. `ptr` = 0 after reset.
- Captured values are final:
  - `addr`/`wdata` changes after the IDLE capture are ignored.
  - Deasserting `req` after capture does not cancel the write; `gnt` is still issued.
- Requester rule: deassert `req` in the cycle after seeing `gnt`. Any `req` high when the block is in IDLE counts as a new request.
- `latch_d` holds its last value in IDLE. It changes only on the IDLE→SETUP transition.
- No write is ever dropped or merged. Requests are served strictly one at a time.

## Timing
- Reset: a rising edge with `rst_n`=0 forces state IDLE, `ptr`=0 and all capture registers to 0.
  - Outputs after reset: `gnt`=0, `latch_d`=0, `latch_en`=0, `busy`=0.
  - Reset takes priority over every other event, including mid-GATE; `latch_en` drops after that edge. Latch contents are not cleared.
- Latency: request seen high at edge E (in IDLE). Then:
  - SETUP during cycle E+1; `busy` rises at E+1.
  - `latch_en` high during cycle E+2.
  - `gnt` high during cycle E+3.
  - Back in IDLE during E+4; `busy` falls at E+4.
- Throughput: one write per 4 cycles when `req` is held continuously.
- `latch_d` is stable from one cycle before `latch_en` rises until one cycle after it falls (setup ≥1 cycle, hold ≥1 cycle).
- At most one bit of `latch_en` and at most one bit of `gnt` is high in any cycle. Never both in the same cycle.
- Simultaneous requests: resolved only by `ptr`. Losers keep `req` high and are re-evaluated in the next IDLE cycle.

## Test plan
- Single write: after reset, req=4'b0001, addr0=2, wdata0=8'hA5.
  - SETUP: `latch_d`=A5, `latch_en`=0.
  - Next cycle: `latch_en`=4'b0100.
  - Next cycle: `gnt`=4'b0001, `latch_en`=0.
  - Then `busy`=0.
- Contention: req=4'b1010 held after reset. Grant order is 1, 3, 1, 3. `gnt` pulses are 4 cycles apart.
- Full round-robin: req=4'b1111 held, with addr i = i and wdata i = 8'h10+i.
  - `gnt` order is 0, 1, 2, 3, 0.
  - `latch_en` follows 0001, 0010, 0100, 1000.
  - `latch_d` = 10, 11, 12, 13.
- Late change: wdata0 switches from 8'h3C to 8'hFF and `req` drops during SETUP.
  - `latch_d` stays 3C through HOLD.
  - `gnt[0]` still pulses.
- Reset mid-write: `rst_n`=0 during GATE.
  - Next cycle: `latch_en`=0, `gnt`=0, `busy`=0, `latch_d`=0.
  - After release with req=4'b0110, requester 1 wins (`ptr` reset to 0).
- Idle stability: `req`=0 for 20 cycles after a write. `latch_d` holds the last value; `latch_en`, `gnt` and `busy` stay 0.
